// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. Load hits return data combinationally; misses stall the whole
// pipeline while the victim line is written back (if dirty) and the
// requested line is fetched from the slow data memory.
module dcache_ctrl #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_write_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WORD_W = $clog2(LINE_BITS / 32);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } stateT;

  stateT stateReg;
  stateT stateNext;

  // Line storage. Tag and data need no reset: valid bits gate their use.
  logic [TAG_W-1:0]     tagArr  [LINES];
  logic [LINE_BITS-1:0] dataArr [LINES];
  logic [LINES-1:0]     validBits;
  logic [LINES-1:0]     dirtyBits;

  // Request decode
  logic [TAG_W-1:0]     reqTag;
  logic [IDX_W-1:0]     reqIdx;
  logic [WORD_W-1:0]    reqWord;
  logic [WORD_W+4:0]    wordBitOff;
  logic [LINE_BITS-1:0] curLine;
  logic [31:0]          curWord;
  logic                 hit;
  logic                 lineDirty;

  // Datapath controls produced by the FSM
  logic                 fillEn;
  logic                 storeEn;
  logic                 stallReq;

  // Byte-offset bits below word granularity carry no information.
  logic                 unusedAddrBits;
  assign unusedAddrBits = &{1'b0, p1_addr_i[1:0]};

  assign reqTag     = p1_addr_i[31 -: TAG_W];
  assign reqIdx     = p1_addr_i[OFF_W +: IDX_W];
  assign reqWord    = p1_addr_i[2 +: WORD_W];
  assign wordBitOff = {reqWord, 5'b00000};
  assign curLine    = dataArr[reqIdx];
  assign curWord    = curLine[wordBitOff +: 32];
  assign lineDirty  = validBits[reqIdx] & dirtyBits[reqIdx];
  assign hit        = p1_req_i & validBits[reqIdx] & (tagArr[reqIdx] == reqTag);

  // Load data is only presented on a load hit; zero otherwise.
  assign p1_data_o  = (hit && !p1_write_i) ? curWord : 32'h0;

  // Reset releases the pipeline immediately, even mid-miss.
  assign p1_stall_o = stallReq & ~rst_i;

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic and memory-side outputs.
  always_comb begin
    stateNext    = stateReg;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    stallReq     = 1'b0;
    fillEn       = 1'b0;
    storeEn      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (p1_req_i && !hit) begin
          stallReq  = 1'b1;
          stateNext = lineDirty ? WRITEBACK : ALLOCATE;
        end else if (hit && p1_write_i) begin
          storeEn = 1'b1;
        end
      end
      WRITEBACK: begin
        // Victim address comes from the still-resident tag.
        stallReq     = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tagArr[reqIdx], reqIdx, {OFF_W{1'b0}}};
        mem_data_o   = curLine;
        if (mem_ack_i) begin
          stateNext = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stallReq     = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {reqTag, reqIdx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fillEn    = 1'b1;
          stateNext = REFILL;
        end
      end
      REFILL: begin
        // One settling cycle; the access completes as a hit in IDLE.
        stallReq  = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Valid/dirty bookkeeping: fill makes a line clean, a store hit dirties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (fillEn) begin
      validBits[reqIdx] <= 1'b1;
      dirtyBits[reqIdx] <= 1'b0;
    end else if (storeEn) begin
      dirtyBits[reqIdx] <= 1'b1;
    end
  end

  // Tag and data arrays: line fill from memory or single-word store.
  always_ff @(posedge clk_i) begin
    if (fillEn) begin
      tagArr[reqIdx]  <= reqTag;
      dataArr[reqIdx] <= mem_data_i;
    end else if (storeEn) begin
      dataArr[reqIdx][wordBitOff +: 32] <= p1_data_i;
    end
  end

endmodule
